// File: rtl/cam_pkg.sv
// Shared types and helpers for the CAM multi-match sequencer.
// Optional hit counters are enabled by defining CAM_MSEQ_HIT_CNT_EN.
package cam_pkg;

   localparam int MAX_DEPTH = 128;

   typedef enum logic {
      IDLE = 1'b0,
      SCAN = 1'b1
   } seq_state_e;

   // Removes the lowest set bit; callers zero-extend narrower vectors and truncate the result.
   function automatic logic [MAX_DEPTH-1:0] clear_lsb(input logic [MAX_DEPTH-1:0] vec);
      return vec & (vec - MAX_DEPTH'(1));
   endfunction

endpackage

// File: rtl/cam_match_seq_prienc_lsb.sv
// LSB-priority encoder: returns the index of the lowest set input bit (0 when none is set).
module prienc_lsb #(
   parameter  int IN_WIDTH = 32,
   localparam int OUT_W    = (IN_WIDTH > 1) ? $clog2(IN_WIDTH) : 1
) (
   input  logic [IN_WIDTH-1:0] i_vec,
   output logic [OUT_W-1:0]    o_addr,
   output logic                o_valid
);

   localparam int PAD_W = 2 ** OUT_W;

   logic [PAD_W-1:0] w_padded;

   // Inputs above IN_WIDTH-1 are tied to zero so non-power-of-two widths never report phantom entries.
   assign w_padded = PAD_W'(i_vec);
   assign o_valid  = |w_padded;

   always_comb begin
      o_addr = '0;
      for (int i = PAD_W - 1; i >= 0; i--) begin
         if (w_padded[i]) begin
            o_addr = OUT_W'(i);
         end
      end
   end

endmodule

// File: rtl/cam_match_seq.sv
// Multi-match sequencer: emits each set bit of a CAM match vector, lowest entry first.
// Define CAM_MSEQ_HIT_CNT_EN to add the o_hit_idx / o_hit_total counter outputs.
module cam_match_seq
   import cam_pkg::*;
#(
   parameter  int DEPTH  = 32,
   localparam int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_match_valid,
   output logic              o_match_ready,
   input  logic [DEPTH-1:0]  i_match_vec,
   input  logic              i_flush,
   output logic              o_hit_valid,
   input  logic              i_hit_ready,
   output logic [ADDR_W-1:0] o_hit_addr,
   output logic              o_hit_last,
   output logic              o_miss,
   output logic              o_busy
`ifdef CAM_MSEQ_HIT_CNT_EN
   ,
   output logic [ADDR_W:0]   o_hit_idx,
   output logic [ADDR_W:0]   o_hit_total
`endif
);

   seq_state_e        r_state;
   seq_state_e        w_stateNext;
   logic [DEPTH-1:0]  r_pending;
   logic [DEPTH-1:0]  w_pendingNext;
   logic [DEPTH-1:0]  w_pendingCleared;
   logic              r_miss;
   logic              w_missNext;
   logic              w_accept;
   logic              w_hitXfer;
   logic              w_pendingNz;
   logic [ADDR_W-1:0] w_encAddr;

   prienc_lsb #(
      .IN_WIDTH (DEPTH)
   ) u_prienc (
      .i_vec   (r_pending),
      .o_addr  (w_encAddr),
      .o_valid (w_pendingNz)
   );

   assign w_pendingCleared = DEPTH'(clear_lsb(MAX_DEPTH'(r_pending)));

   assign o_match_ready = (r_state == IDLE) && !i_flush;
   assign o_hit_valid   = (r_state == SCAN);
   assign o_busy        = (r_state != IDLE);
   assign o_hit_addr    = w_encAddr;
   assign o_hit_last    = w_pendingNz && (w_pendingCleared == '0);
   assign o_miss        = r_miss;

   assign w_accept  = i_match_valid && o_match_ready;
   assign w_hitXfer = o_hit_valid && i_hit_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= IDLE;
         r_pending <= '0;
         r_miss    <= 1'b0;
      end else begin
         r_state   <= w_stateNext;
         r_pending <= w_pendingNext;
         r_miss    <= w_missNext;
      end
   end

   // Flush overrides everything; a handshake in the flush cycle has already been seen by the consumer.
   always_comb begin
      w_stateNext   = r_state;
      w_pendingNext = r_pending;
      w_missNext    = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_accept) begin
               w_pendingNext = i_match_vec;
               if (i_match_vec != '0) begin
                  w_stateNext = SCAN;
               end else begin
                  w_missNext = 1'b1;
               end
            end
         end
         SCAN: begin
            if (w_hitXfer) begin
               w_pendingNext = w_pendingCleared;
               if (o_hit_last) begin
                  w_stateNext = IDLE;
               end
            end
         end
         default: begin
            w_stateNext   = IDLE;
            w_pendingNext = '0;
         end
      endcase
      if (i_flush) begin
         w_stateNext   = IDLE;
         w_pendingNext = '0;
         w_missNext    = 1'b0;
      end
   end

`ifdef CAM_MSEQ_HIT_CNT_EN
   localparam int CNT_W = ADDR_W + 1;

   logic [CNT_W-1:0] r_hitIdx;
   logic [CNT_W-1:0] r_hitTotal;
   logic [CNT_W-1:0] w_popCount;

   always_comb begin
      w_popCount = '0;
      for (int i = 0; i < DEPTH; i++) begin
         w_popCount = w_popCount + CNT_W'(i_match_vec[i]);
      end
   end

   // The total survives flush so the consumer can still see how large the aborted vector was.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_hitIdx   <= '0;
         r_hitTotal <= '0;
      end else begin
         if (i_flush || w_accept) begin
            r_hitIdx <= '0;
         end else if (w_hitXfer) begin
            r_hitIdx <= r_hitIdx + CNT_W'(1);
         end
         if (w_accept) begin
            r_hitTotal <= w_popCount;
         end
      end
   end

   assign o_hit_idx   = r_hitIdx;
   assign o_hit_total = r_hitTotal;
`endif

endmodule

// File: tb/tb_cam_match_seq.sv
// Self-checking bench for cam_match_seq: vector table, directed corner cases, randomized model check.
module tb_cam_match_seq;

   typedef struct {
      string       name;
      logic [31:0] vec;
      int          expCount;
      int          expFirst;
      int          expLast;
      bit          expMiss;
   } vecCase_t;

   logic clk = 1'b0;
   logic rst_n;

   logic        m32Valid, m32Ready, f32, hv32, hr32, hl32, miss32, busy32;
   logic [31:0] m32Vec;
   logic [4:0]  ha32;

   logic        m20Valid, m20Ready, f20, hv20, hr20, hl20, miss20, busy20;
   logic [19:0] m20Vec;
   logic [4:0]  ha20;

`ifdef CAM_MSEQ_HIT_CNT_EN
   logic [5:0] hi32, ht32, hi20, ht20;
`endif

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   cam_match_seq #(.DEPTH(32)) dut32 (
      .clk           (clk),
      .rst_n         (rst_n),
      .i_match_valid (m32Valid),
      .o_match_ready (m32Ready),
      .i_match_vec   (m32Vec),
      .i_flush       (f32),
      .o_hit_valid   (hv32),
      .i_hit_ready   (hr32),
      .o_hit_addr    (ha32),
      .o_hit_last    (hl32),
      .o_miss        (miss32),
      .o_busy        (busy32)
`ifdef CAM_MSEQ_HIT_CNT_EN
      ,
      .o_hit_idx     (hi32),
      .o_hit_total   (ht32)
`endif
   );

   cam_match_seq #(.DEPTH(20)) dut20 (
      .clk           (clk),
      .rst_n         (rst_n),
      .i_match_valid (m20Valid),
      .o_match_ready (m20Ready),
      .i_match_vec   (m20Vec),
      .i_flush       (f20),
      .o_hit_valid   (hv20),
      .i_hit_ready   (hr20),
      .o_hit_addr    (ha20),
      .o_hit_last    (hl20),
      .o_miss        (miss20),
      .o_busy        (busy20)
`ifdef CAM_MSEQ_HIT_CNT_EN
      ,
      .o_hit_idx     (hi20),
      .o_hit_total   (ht20)
`endif
   );

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic valid, input logic [31:0] vec, input logic hitReady, input logic flush);
      m32Valid = valid;
      m32Vec   = vec;
      hr32     = hitReady;
      f32      = flush;
   endtask

   task automatic applyStimulus20(input logic valid, input logic [19:0] vec, input logic hitReady, input logic flush);
      m20Valid = valid;
      m20Vec   = vec;
      hr20     = hitReady;
      f20      = flush;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   vecCase_t cases[6];

   // Behavioural model state for the randomized phase
   int   expQ[$];
   bit   expMiss;
   int   expIdx;
   int   expTotal;
   bit   cntKnown;

   initial begin
      cases[0] = '{"single",    32'h0000_0100, 1,  8,  8,  1'b0};
      cases[1] = '{"multi",     32'h8000_0011, 3,  0,  31, 1'b0};
      cases[2] = '{"miss",      32'h0000_0000, 0,  -1, -1, 1'b1};
      cases[3] = '{"all_ones",  32'hFFFF_FFFF, 32, 0,  31, 1'b0};
      cases[4] = '{"bit0",      32'h0000_0001, 1,  0,  0,  1'b0};
      cases[5] = '{"bit31",     32'h8000_0000, 1,  31, 31, 1'b0};

      rst_n = 1'b0;
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
      applyStimulus20(1'b0, 20'h0, 1'b0, 1'b0);
      #12;
      checkOutput("reset_hit_valid", 32'(hv32), 32'd0);
      checkOutput("reset_miss", 32'(miss32), 32'd0);
      checkOutput("reset_busy", 32'(busy32), 32'd0);
      checkOutput("reset_match_ready", 32'(m32Ready), 32'd1);
      checkOutput("reset_hit_addr", 32'(ha32), 32'd0);
      checkOutput("reset_hit_last", 32'(hl32), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      // Table-driven single-vector drains with the consumer always ready
      for (int t = 0; t < 6; t++) begin
         int n, first, lastA, lastPos, busyCnt;
         n = 0; first = -1; lastA = -1; lastPos = -1; busyCnt = 0;
         applyStimulus(1'b1, cases[t].vec, 1'b1, 1'b0);
         settle();
         checkOutput({cases[t].name, "_ready_before"}, 32'(m32Ready), 32'd1);
         tick();
         applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
         settle();
         checkOutput({cases[t].name, "_miss"}, 32'(miss32), 32'(cases[t].expMiss));
         for (int c = 0; c < 40 && hv32; c++) begin
            if (busy32) busyCnt++;
            if (n == 0) first = int'(ha32);
            lastA = int'(ha32);
            if (hl32) lastPos = n;
            n++;
            tick();
            settle();
         end
         if (n == 0) begin
            tick();
            settle();
         end
         checkOutput({cases[t].name, "_count"}, 32'(n), 32'(cases[t].expCount));
         checkOutput({cases[t].name, "_busy_cycles"}, 32'(busyCnt), 32'(cases[t].expCount));
         checkOutput({cases[t].name, "_first"}, 32'(first), 32'(cases[t].expFirst));
         checkOutput({cases[t].name, "_last"}, 32'(lastA), 32'(cases[t].expLast));
         checkOutput({cases[t].name, "_last_pos"}, 32'(lastPos), 32'(cases[t].expCount - 1));
         checkOutput({cases[t].name, "_ready_after"}, 32'(m32Ready), 32'd1);
         checkOutput({cases[t].name, "_miss_after"}, 32'(miss32), 32'd0);
      end

      // Backpressure: the first hit must hold while the consumer stalls, and new vectors are refused
      applyStimulus(1'b1, 32'h0000_0006, 1'b0, 1'b0);
      settle();
      tick();
      applyStimulus(1'b1, 32'h0000_FFFF, 1'b0, 1'b0);
      for (int c = 0; c < 3; c++) begin
         settle();
         checkOutput("bp_hold_valid", 32'(hv32), 32'd1);
         checkOutput("bp_hold_addr", 32'(ha32), 32'd1);
         checkOutput("bp_hold_last", 32'(hl32), 32'd0);
         checkOutput("bp_hold_ready", 32'(m32Ready), 32'd0);
         tick();
      end
      hr32 = 1'b1;
      settle();
      checkOutput("bp_rel_addr0", 32'(ha32), 32'd1);
      tick();
      m32Valid = 1'b0;
      settle();
      checkOutput("bp_rel_addr1", 32'(ha32), 32'd2);
      checkOutput("bp_rel_last1", 32'(hl32), 32'd1);
      checkOutput("bp_rel_ready", 32'(m32Ready), 32'd0);
      tick();
      settle();
      checkOutput("bp_done_valid", 32'(hv32), 32'd0);
      checkOutput("bp_done_ready", 32'(m32Ready), 32'd1);

      // Flush after the first handshake; the handshake in the flush cycle is consumed
      applyStimulus(1'b1, 32'h0000_000F, 1'b1, 1'b0);
      settle();
      tick();
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
      settle();
      checkOutput("fl_addr0", 32'(ha32), 32'd0);
      tick();
      f32 = 1'b1;
      settle();
      checkOutput("fl_addr1", 32'(ha32), 32'd1);
      tick();
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
      settle();
      checkOutput("fl_valid_after", 32'(hv32), 32'd0);
      checkOutput("fl_miss_after", 32'(miss32), 32'd0);
      checkOutput("fl_busy_after", 32'(busy32), 32'd0);
      checkOutput("fl_ready_after", 32'(m32Ready), 32'd1);
      applyStimulus(1'b1, 32'h0, 1'b1, 1'b1);
      settle();
      checkOutput("fl_idle_blocks_ready", 32'(m32Ready), 32'd0);
      tick();
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
      settle();
      checkOutput("fl_idle_no_miss", 32'(miss32), 32'd0);
      applyStimulus(1'b1, 32'h0000_0020, 1'b1, 1'b0);
      settle();
      tick();
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
      settle();
      checkOutput("fl_next_valid", 32'(hv32), 32'd1);
      checkOutput("fl_next_addr", 32'(ha32), 32'd5);
      checkOutput("fl_next_last", 32'(hl32), 32'd1);
      tick();
      settle();
      checkOutput("fl_next_done", 32'(hv32), 32'd0);

      // Reset mid-sequence on the 20-entry instance, then use the top valid entry
      applyStimulus20(1'b1, 20'h80001, 1'b1, 1'b0);
      settle();
      tick();
      applyStimulus20(1'b0, 20'h0, 1'b1, 1'b0);
      settle();
      checkOutput("r20_addr0", 32'(ha20), 32'd0);
      tick();
      settle();
      checkOutput("r20_addr1", 32'(ha20), 32'd19);
      checkOutput("r20_valid1", 32'(hv20), 32'd1);
      #1;
      rst_n = 1'b0;
      #1;
      checkOutput("r20_rst_valid", 32'(hv20), 32'd0);
      checkOutput("r20_rst_busy", 32'(busy20), 32'd0);
      checkOutput("r20_rst_ready", 32'(m20Ready), 32'd1);
      checkOutput("r20_rst_addr", 32'(ha20), 32'd0);
      checkOutput("r20_rst_last", 32'(hl20), 32'd0);
      checkOutput("r20_rst_miss", 32'(miss20), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      applyStimulus20(1'b1, 20'h80000, 1'b1, 1'b0);
      settle();
      tick();
      applyStimulus20(1'b0, 20'h0, 1'b1, 1'b0);
      settle();
      checkOutput("r20_top_valid", 32'(hv20), 32'd1);
      checkOutput("r20_top_addr", 32'(ha20), 32'd19);
      checkOutput("r20_top_last", 32'(hl20), 32'd1);
      tick();
      settle();
      checkOutput("r20_top_done", 32'(hv20), 32'd0);

      // Randomized traffic on the 32-entry instance against a queue-of-addresses model
      expQ.delete();
      expMiss  = 1'b0;
      expIdx   = 0;
      expTotal = 0;
      cntKnown = 1'b0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         logic        v, hr, fl;
         logic [31:0] vec;
         int          kind;
         kind = int'($urandom_range(0, 3));
         case (kind)
            0:       vec = 32'h0;
            1:       vec = 32'h1 << $urandom_range(0, 31);
            2:       vec = $urandom & $urandom & $urandom;
            default: vec = $urandom;
         endcase
         v  = 1'($urandom_range(0, 1));
         hr = ($urandom_range(0, 3) != 0);
         fl = ($urandom_range(0, 24) == 0);
         applyStimulus(v, vec, hr, fl);
         settle();
         checkOutput("rnd_ready", 32'(m32Ready), 32'((expQ.size() == 0) && !fl));
         checkOutput("rnd_valid", 32'(hv32), 32'(expQ.size() != 0));
         checkOutput("rnd_busy", 32'(busy32), 32'(expQ.size() != 0));
         checkOutput("rnd_addr", 32'(ha32), 32'((expQ.size() != 0) ? expQ[0] : 0));
         checkOutput("rnd_last", 32'(hl32), 32'(expQ.size() == 1));
         checkOutput("rnd_miss", 32'(miss32), 32'(expMiss));
`ifdef CAM_MSEQ_HIT_CNT_EN
         if (cntKnown) begin
            checkOutput("rnd_hit_idx", 32'(hi32), 32'(expIdx));
            checkOutput("rnd_hit_total", 32'(ht32), 32'(expTotal));
         end
`endif
         expMiss = 1'b0;
         if (fl) begin
            if (expQ.size() != 0 && hr) void'(expQ.pop_front());
            expQ.delete();
            expIdx = 0;
         end else if (expQ.size() == 0) begin
            if (v) begin
               for (int b = 0; b < 32; b++) begin
                  if (vec[b]) expQ.push_back(b);
               end
               expMiss  = (vec == 32'h0);
               expIdx   = 0;
               expTotal = $countones(vec);
               cntKnown = 1'b1;
            end
         end else if (hr) begin
            void'(expQ.pop_front());
            expIdx++;
         end
         tick();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
